// File: rtl/rvhazard_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : rvhazard_monitor_if
// Description : Bundle of every signal exchanged between the 5-stage core
//               (hazard unit + datapath observation points) and the hazard
//               protocol monitor. The core side drives the observed pipeline
//               signals and the clear strobe; the monitor side drives the
//               violation pulses, sticky flags, counters, first-failure
//               record and free-running cycle count.
//   master : core / environment side (drives observations, reads results)
//   slave  : monitor side (reads observations, drives results)
// Revision    : 1.0 - initial release
// ============================================================================
interface rvhazard_monitor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16,
    parameter int TS_W  = 32
);
    // observation inputs to the monitor
    logic                clr;
    logic [XLEN-1:0]     X0Value;
    logic                StallD;
    logic                FlushD;
    logic                PCSrcE;
    logic [31:0]         InstrD;
    logic [4:0]          rdE;
    logic [1:0]          ResultSrcE;
    logic [1:0]          ForwardAE;
    logic [1:0]          ForwardBE;
    logic [XLEN-1:0]     SrcAE;
    logic [XLEN-1:0]     SrcBE;
    logic [XLEN-1:0]     ALUResultM;
    logic [XLEN-1:0]     ResultW;

    // monitor results
    logic [6:0]          fail_pulse;
    logic [6:0]          sticky_err;
    logic [7*CNT_W-1:0]  err_cnt;
    logic                first_valid;
    logic [2:0]          first_id;
    logic [TS_W-1:0]     first_ts;
    logic [TS_W-1:0]     cycle_cnt;

    modport master (
        output clr, X0Value, StallD, FlushD, PCSrcE, InstrD, rdE, ResultSrcE,
               ForwardAE, ForwardBE, SrcAE, SrcBE, ALUResultM, ResultW,
        input  fail_pulse, sticky_err, err_cnt, first_valid, first_id,
               first_ts, cycle_cnt
    );

    modport slave (
        input  clr, X0Value, StallD, FlushD, PCSrcE, InstrD, rdE, ResultSrcE,
               ForwardAE, ForwardBE, SrcAE, SrcBE, ALUResultM, ResultW,
        output fail_pulse, sticky_err, err_cnt, first_valid, first_id,
               first_ts, cycle_cnt
    );
endinterface
`default_nettype wire

// File: rtl/rvhazard_monitor.sv
`default_nettype none
// ============================================================================
// Module      : rvhazard_monitor
// Description : Registered hazard-protocol monitor for the 5-stage RISC-V
//               core. Every cycle seven hazard-unit invariants are evaluated:
//                 0 X0       - register x0 reads non-zero
//                 1 LOADUSE  - load-use dependency not stalled
//                 2 FLUSH    - taken branch without decode flush
//                 3 HOLD     - decode instruction changed while stalled
//                 4 FWDA     - forwarded operand A differs from its source
//                 5 FWDB     - forwarded operand B differs from its source
//                 6 WATCHDOG - StallD held longer than MAX_STALL cycles
//               Violations are reported one cycle later as a pulse, a sticky
//               flag, a saturating per-check counter and a first-failure
//               record (id + timestamp). The monitor never drives the core.
// Ports       : clk   - clock, all state updates on rising edge
//               reset - synchronous active-high, clears all state
//               bus   - rvhazard_monitor_if slave modport (observations in,
//                       clr in, results out)
// Revision    : 1.0 - initial release
// ============================================================================
module rvhazard_monitor #(
    parameter int         XLEN      = 32,
    parameter int         CNT_W     = 16,
    parameter int         TS_W      = 32,
    parameter int         MAX_STALL = 4,       // must be >= 1
    parameter logic [6:0] CHECK_EN  = 7'h7F
) (
    input  wire logic            clk,
    input  wire logic            reset,
    rvhazard_monitor_if.slave    bus
);

    localparam int               c_RUN_W   = $clog2(MAX_STALL + 1);
    localparam logic [c_RUN_W-1:0] c_MAX_RUN = c_RUN_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Registered history of the previous cycle
    // ------------------------------------------------------------------
    logic [c_RUN_W-1:0] r_stall_run;
    logic [31:0]        r_instr_q;
    logic               r_prev_stall;
    logic               r_prev_flush;

    logic [6:0]         r_fail_pulse;
    logic [6:0]         r_sticky;
    logic               r_first_valid;
    logic [2:0]         r_first_id;
    logic [TS_W-1:0]    r_first_ts;
    logic [TS_W-1:0]    r_cycle_cnt;

    logic [6:0]         w_v;
    logic [6:0]         w_e;
    logic [2:0]         w_first_id;
    logic               w_clear;

    // ResultSrcE[1] only distinguishes non-load result kinds; not needed.
    logic               w_unused_rsrc;
    assign w_unused_rsrc = bus.ResultSrcE[1];

    // ------------------------------------------------------------------
    // Raw invariant evaluation
    // ------------------------------------------------------------------
    always_comb begin
        w_v    = '0;
        w_v[0] = (bus.X0Value != '0);
        w_v[1] = bus.ResultSrcE[0] && (bus.rdE != 5'd0) &&
                 ((bus.InstrD[19:15] == bus.rdE) || (bus.InstrD[24:20] == bus.rdE)) &&
                 !bus.StallD;
        w_v[2] = bus.PCSrcE && !bus.FlushD;
        // A stalled decode must present the same instruction next cycle,
        // unless that stall cycle was also flushed.
        w_v[3] = r_prev_stall && !r_prev_flush && (bus.InstrD != r_instr_q);
        w_v[4] = ((bus.ForwardAE == 2'b10) && (bus.SrcAE != bus.ALUResultM)) ||
                 ((bus.ForwardAE == 2'b01) && (bus.SrcAE != bus.ResultW));
        w_v[5] = ((bus.ForwardBE == 2'b10) && (bus.SrcBE != bus.ALUResultM)) ||
                 ((bus.ForwardBE == 2'b01) && (bus.SrcBE != bus.ResultW));
        // r_stall_run saturates at MAX_STALL, so this stays true for every
        // further stall cycle of an over-long run.
        w_v[6] = (r_stall_run == c_MAX_RUN) && bus.StallD;
    end

    // reset/clr win over any coincident violation
    assign w_clear = reset | bus.clr;
    assign w_e     = w_v & CHECK_EN & {7{~w_clear}};

    // lowest violating id for the first-failure record
    always_comb begin
        w_first_id = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (w_e[i]) begin
                w_first_id = 3'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Free-running cycle counter (clr does not touch it)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline history; tracked regardless of CHECK_EN
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_stall_run  <= '0;
            r_instr_q    <= '0;
            r_prev_stall <= 1'b0;
            r_prev_flush <= 1'b0;
        end else begin
            if (!bus.StallD) begin
                r_stall_run <= '0;
            end else if (r_stall_run != c_MAX_RUN) begin
                r_stall_run <= r_stall_run + 1'b1;
            end
            r_instr_q    <= bus.InstrD;
            r_prev_stall <= bus.StallD;
            r_prev_flush <= bus.FlushD;
        end
    end

    // ------------------------------------------------------------------
    // Pulse, sticky and first-failure record
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_fail_pulse  <= '0;
            r_sticky      <= '0;
            r_first_valid <= 1'b0;
            r_first_id    <= '0;
            r_first_ts    <= '0;
        end else begin
            r_fail_pulse <= w_e;
            r_sticky     <= r_sticky | w_e;
            if (!r_first_valid && (w_e != '0)) begin
                r_first_valid <= 1'b1;
                r_first_id    <= w_first_id;
                r_first_ts    <= r_cycle_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating per-check violation counters
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 7; gi++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (w_clear) begin
                r_cnt <= '0;
            end else if (w_e[gi] && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign bus.err_cnt[gi*CNT_W +: CNT_W] = r_cnt;
    end

    assign bus.fail_pulse  = r_fail_pulse;
    assign bus.sticky_err  = r_sticky;
    assign bus.first_valid = r_first_valid;
    assign bus.first_id    = r_first_id;
    assign bus.first_ts    = r_first_ts;
    assign bus.cycle_cnt   = r_cycle_cnt;

    // Simulation-only violation log; enabled by defining
    // RVHAZARD_MONITOR_MESSAGES in simulation builds, never in synthesis.
`ifdef RVHAZARD_MONITOR_MESSAGES
    always_ff @(posedge clk) begin
        for (int i = 0; i < 7; i++) begin
            if (w_e[i]) begin
                $error("rvhazard_monitor: check %0d violated at cycle %0d", i, r_cycle_cnt);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/rvhazard_monitor.md
# rvhazard_monitor

Parametrised, synthesisable hazard-protocol monitor for the 5-stage RISC-V core, in the same checker role as the hazard SVA bind but with registered state. Each cycle it evaluates seven hazard-unit invariants: x0, load-use stall, branch flush, decode hold, forwarding A/B and a stall watchdog. It keeps per-check saturating violation counters, sticky flags and a first-failure record with timestamp, so failures are visible on silicon, FPGA and in simulation. Instantiated beside the core and connected to hazard-unit and datapath signals; it drives nothing back into the pipeline.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, width of each violation counter
- TS_W, 32, width of cycle counter / timestamp
- MAX_STALL, 4, max legal consecutive StallD cycles (≥1)
- CHECK_EN, 7'h7F, per-check enable mask, bit i = check i

- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high; clears all state
- clr  in  1  synchronous clear of counters, sticky, first-failure record; cycle_cnt unaffected
- X0Value  in  XLEN  current regfile x0 contents
- StallD, FlushD, PCSrcE  in  1 each  hazard-unit outputs / branch taken
- InstrD  in  32  decode-stage instruction
- rdE  in  5;  ResultSrcE  in  2  execute-stage destination / result select (bit0 = load)
- ForwardAE, ForwardBE  in  2 each  forward selects (00 reg, 01 W, 10 M)
- SrcAE, SrcBE  in  XLEN  forwarded operands (SrcBE before immediate mux)
- ALUResultM, ResultW  in  XLEN  M- and W-stage forward sources
- fail_pulse  out  7  registered per-check violation, one cycle
- sticky_err  out  7  per-check sticky flag
- err_cnt  out  7*CNT_W  counters, check i at [i*CNT_W +: CNT_W]
- first_valid  out  1;  first_id  out  3;  first_ts  out  TS_W  first-failure record
- cycle_cnt  out  TS_W  free-running cycle count

## Operation
- Check IDs, raw condition v[i] evaluated combinationally in cycle N:
  - 0 X0: X0Value != 0
  - 1 LOADUSE: ResultSrcE[0] && rdE!=0 && (InstrD[19:15]==rdE || InstrD[24:20]==rdE) && !StallD
  - 2 FLUSH: PCSrcE && !FlushD
  - 3 HOLD: prev_stall && !prev_flush && InstrD != instr_q. instr_q, prev_stall and prev_flush are registered copies from N-1. prev_stall=0 after reset/clr, so no check in the first cycle.
  - 4 FWDA: (ForwardAE==10 && SrcAE!=ALUResultM) || (ForwardAE==01 && SrcAE!=ResultW); 11 = no check
  - 5 FWDB: same with ForwardBE/SrcBE
  - 6 WATCHDOG: stall_run == MAX_STALL && StallD. stall_run counts consecutive StallD cycles (0 when StallD=0, saturates at MAX_STALL). Fires every cycle the run exceeds MAX_STALL.
- Effective violation e[i] = v[i] & CHECK_EN[i] & !reset & !clr.
- On posedge: fail_pulse <= e. For each i with e[i]: sticky_err[i] <= 1 and err_cnt[i] += 1, saturating at 2^CNT_W-1 with no wrap.
- First-failure record: if !first_valid and e != 0, set first_valid=1, first_id = lowest set index of e and first_ts = cycle_cnt of cycle N. It is then frozen until reset/clr.
- cycle_cnt increments every non-reset cycle and wraps modulo 2^TS_W.
- Simulation-only: one error message per set e[i], giving ID and cycle_cnt. It is excluded from synthesis.

## Timing
- Reset (sync): fail_pulse, sticky_err, err_cnt, first_valid, first_id, first_ts, cycle_cnt, stall_run, instr_q, prev_stall, prev_flush all 0. Reset asserted mid-run clears everything on that edge. The monitor checks again in the cycle after reset deasserts, except HOLD, which starts one cycle later.
- clr has the same effect except cycle_cnt continues. A violation coincident with clr is dropped because clr wins.
- Latency: violation in cycle N → fail_pulse, sticky, counter, record visible in cycle N+1.
- Simultaneous violations: all counters update in the same edge, and first_id takes the lowest ID.
- Disabled checks never count. Toggling CHECK_EN is not supported; it is a parameter.
- stall_run is tracked even when check 6 is disabled. clr resets stall_run to 0.

## Test plan
- Reset, then 10 clean cycles → all outputs 0, cycle_cnt=10.
- Load x5 in E (ResultSrcE=01, rdE=5) with InstrD rs1=5 and StallD=0 in cycle 20 → fail_pulse=7'b0000010 at cycle 21, err_cnt[1]=1, first_id=1, first_ts=20. Repeat with StallD=1 → no change.
- PCSrcE=1, FlushD=0, and ForwardAE=10 with SrcAE≠ALUResultM in the same cycle → fail_pulse bits 2 and 4 set, first_id=2, both counters +1.
- StallD held 6 cycles with MAX_STALL=4 → check 6 fires on stall cycles 5 and 6 (err_cnt[6]=2). InstrD changes in stall cycle 3 → check 3 fires once.
- CNT_W=2, 5 consecutive x0 violations → err_cnt[0] saturates at 3, sticky_err[0]=1. Then assert clr together with a violation → all record/counters 0 next cycle and cycle_cnt keeps counting.
